pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures the high and low durations of an incoming pulse-width-modulated signal in `clk` cycles and reports them once per complete period. It is the receive-side counterpart of the PWM generator: it recovers the `T_HIGH`/`T_LOW` pair that produced a waveform. Typical uses are closed-loop checks of brightness/timing pulses in the OLED controller and decoding of externally generated PWM.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pulse_in`. Legal values are 2 or 3.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst == 0` resets).
- `en`  in  1  capture enable.
- `pulse_in`  in  1  asynchronous PWM input.
- `t_high`  out  `byte2_t`  last measured high time, in cycles.
- `t_low`  out  `byte2_t`  last measured low time, in cycles.
- `valid`  out  1  one-cycle strobe; `t_high`/`t_low`/`ovf` are new in this cycle.
- `ovf`  out  1  set if either phase of the reported period saturated.

## Operation
- `pulse_in` passes through `SYNC_STAGES` flops to give `s`, plus one delay flop `s_d`.
  - rise = `s & ~s_d`
  - fall = `~s & s_d`
- Phase counter `cnt` is a `byte2_t`:
  - Loaded with 1 on any detected edge.
  - Otherwise incremented each cycle.
  - Saturates at 16'hFFFF and sets a per-period `sat` flag.
- FSM states and transitions:
  - WAIT_LOW → ARM when `s == 0`. This discards a partial high phase.
  - ARM → HIGH on rise; `cnt <= 1`, `sat <= 0`.
  - HIGH → LOW on fall; latch `hi_q <= cnt`, `cnt <= 1`.
  - LOW → HIGH on rise:
    - `t_high <= hi_q`, `t_low <= cnt`, `ovf <= sat`, `valid <= 1`.
    - Then `cnt <= 1`, `sat <= 0`.
- Counting rule: a phase lasting N cycles at `s` reports N. The minimum reportable phase is 1.
- `en == 0`:
  - Next state is WAIT_LOW; `cnt <= 0`; `valid <= 0`.
  - `t_high`, `t_low` and `ovf` hold their last values.
  - The synchronizer keeps running.
- A saturated phase stays in its state. No `valid` is produced until the next edge completes the period, which then reports 16'hFFFF with `ovf = 1`.

## Timing
- Reset values:
  - `t_high = 0`, `t_low = 0`, `valid = 0`, `ovf = 0`.
  - State WAIT_LOW, `cnt = 0`.
  - Synchronizer and `s_d` flops = 1, so a high input at reset release is not seen as an edge.
- Latency: `valid` is asserted exactly `SYNC_STAGES + 1` clock edges after the edge that first samples the completing rise of `pulse_in`.
  - Default: 3 cycles.
- `valid` is high for exactly one cycle per period and is never asserted twice without an intervening fall and rise.
- Outputs change only in the `valid` cycle (or on reset).
- Reset mid-period: all state returns to reset values on the next edge; no `valid` is emitted.
- `en` deasserted mid-period: the in-flight period is dropped.
- `en` reasserted: the first `valid` needs a full low, high, low, rise sequence.
- Input held constant forever: no `valid`; the counter sits at 16'hFFFF.

## Structure
- `MyPkg` gains:
  - `typedef enum logic [1:0] {WAIT_LOW, ARM, HIGH, LOW} pwm_cap_state_t`.
  - `localparam byte2_t CNT_MAX = 16'hFFFF`.
- `byte2_t` is reused from `MyPkg`.
- One sub-module, `sync_edge`: parameterized synchronizer plus delay flop, outputting `s`, `rise` and `fall`. It is reusable elsewhere in the controller.
- The FSM, counter and output registers live in `pwm_capture`.

## Test plan
- Directed period: `pulse_in` high 3 / low 5 cycles, repeated → after the first full period, `valid` every 8 cycles with `t_high = 3`, `t_low = 5`, `ovf = 0`.
- Minimum widths: high 1 / low 1 alternating → `t_high = 1`, `t_low = 1`, `valid` every 2 cycles.
- Reset release with `pulse_in = 1` → no `valid` until a low, high, low, rise has occurred. Measured values equal the true widths, with no truncated first phase.
- Saturation: high 70000 cycles, then low 4, then rise → single `valid` with `t_high = 16'hFFFF`, `t_low = 4`, `ovf = 1`. The next normal period reports `ovf = 0`.
- `en` dropped mid-high for 10 cycles → no `valid` for the broken period. Outputs hold their prior values. The next `valid` reports a clean period.
- Latency check: `valid` rises exactly 3 edges after the rise sample (default `SYNC_STAGES`), and 4 edges with `SYNC_STAGES = 3`.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_capture_pkg: shared types and constants for the PWM capture block.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pwm_capture_pkg;

    typedef logic [15:0] byte2_t;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARM      = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } pwm_cap_state_t;

    localparam byte2_t CNT_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_edge: multi-flop synchronizer with delay flop and registered edges. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_s_d;
    logic              r_rise;
    logic              r_fall;
    logic              w_s_cur;

    assign w_s_cur = r_sync[STAGES-1];

    // Flops reset high so a high input at reset release never looks like a rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '1;
            r_s_d  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
            r_s_d  <= w_s_cur;
            r_rise <= w_s_cur & ~r_s_d;
            r_fall <= ~w_s_cur & r_s_d;
        end
    end

    assign s    = r_s_d;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_capture: measures high/low widths of a PWM input once per period.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pulse_in,
    output logic [15:0] t_high,
    output logic [15:0] t_low,
    output logic        valid,
    output logic        ovf
);

    logic           w_s;
    logic           w_rise;
    logic           w_fall;
    pwm_cap_state_t r_state;
    byte2_t         r_cnt;
    byte2_t         r_hi_q;
    logic           r_sat;
    byte2_t         r_t_high;
    byte2_t         r_t_low;
    logic           r_valid;
    logic           r_ovf;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (pulse_in),
        .s    (w_s),
        .rise (w_rise),
        .fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= WAIT_LOW;
            r_cnt    <= 16'd0;
            r_hi_q   <= 16'd0;
            r_sat    <= 1'b0;
            r_t_high <= 16'd0;
            r_t_low  <= 16'd0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (!en) begin
            r_state <= WAIT_LOW;
            r_cnt   <= 16'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Phase counter restarts at 1 so an N-cycle phase reads back as N.
            if (w_rise || w_fall) begin
                r_cnt <= 16'd1;
            end else if (r_cnt == CNT_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                WAIT_LOW: begin
                    if (!w_s) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        r_sat   <= 1'b0;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        r_hi_q  <= r_cnt;
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_t_high <= r_hi_q;
                        r_t_low  <= r_cnt;
                        r_ovf    <= r_sat;
                        r_valid  <= 1'b1;
                        r_sat    <= 1'b0;
                        r_state  <= HIGH;
                    end
                end
                default: begin
                    r_state <= WAIT_LOW;
                end
            endcase
        end
    end

    assign t_high = r_t_high;
    assign t_low  = r_t_low;
    assign valid  = r_valid;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_capture: directed stimulus with a run-length reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pwm_capture;

    // The capture logic acts on an input sample this many edges after it is taken.
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        pulse_in = 1'b1;
    logic [15:0] th2, tl2, th3, tl3;
    logic        v2, o2, v3, o3;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    pwm_capture #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .t_high(th2), .t_low(tl2), .valid(v2), .ovf(o2)
    );

    pwm_capture #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .t_high(th3), .t_low(tl3), .valid(v3), .ovf(o3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        hist [8];
    int          t = 0;
    int          reset_edge = 0;
    int          run = 0;
    int          hi_len = 0;
    bit          armed, started, have_hi;
    logic        cur, prev;
    logic        e_v, e_o;
    logic [15:0] e_th, e_tl;

    function automatic logic seen(input int i);
        if (i <= reset_edge) return 1'b1;
        return hist[i % 8];
    endfunction

    function automatic logic [15:0] clip(input int x);
        logic [31:0] v;
        v = x;
        return (x > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            t++;
            hist[t % 8] = pulse_in;
            if (!rst) begin
                reset_edge = t;
                e_v = 0; e_o = 0; e_th = 16'd0; e_tl = 16'd0;
                armed = 0; started = 0; have_hi = 0; run = 0;
            end else if (!en) begin
                e_v = 0;
                armed = 0; started = 0; have_hi = 0;
            end else begin
                cur  = seen(t - LAT);
                prev = seen(t - LAT - 1);
                e_v  = 0;
                if (cur && !prev) begin
                    if (have_hi) begin
                        e_v  = 1;
                        e_th = clip(hi_len);
                        e_tl = clip(run);
                        e_o  = (hi_len > 65535) || (run > 65535);
                    end
                    if (armed) started = 1;
                    have_hi = 0;
                end else if (!cur && prev && started) begin
                    hi_len  = run;
                    have_hi = 1;
                end
                if (!cur) armed = 1;
                run = (cur != prev) ? 1 : run + 1;
            end
            #1;
            check("valid", {31'd0, v2}, {31'd0, e_v});
            check("t_high", {16'd0, th2}, {16'd0, e_th});
            check("t_low", {16'd0, tl2}, {16'd0, e_tl});
            check("ovf", {31'd0, o2}, {31'd0, e_o});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (v2) vcount++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic phase(input logic level, input int n);
        pulse_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [15:0] eh, input logic [15:0] el,
                              input logic eo);
        check({name, "_th"}, {16'd0, th2}, {16'd0, eh});
        check({name, "_tl"}, {16'd0, tl2}, {16'd0, el});
        check({name, "_ovf"}, {31'd0, o2}, {31'd0, eo});
    endtask

    initial begin
        int lat2, lat3, vc0;

        repeat (3) @(negedge clk);
        expect_out("reset", 16'd0, 16'd0, 1'b0);
        check("reset_valid", {31'd0, v2}, 32'd0);

        // Release with input high: the truncated first high must not be reported.
        rst = 1'b1;
        en  = 1'b1;
        phase(1'b1, 6);
        repeat (4) begin
            phase(1'b0, 5);
            phase(1'b1, 3);
        end
        phase(1'b0, 5);

        pulse_in = 1'b1;
        lat2 = -1;
        lat3 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (v2 && lat2 < 0) lat2 = k - 1;
            if (v3 && lat3 < 0) lat3 = k - 1;
        end
        check("latency_s2", lat2, 32'd3);
        check("latency_s3", lat3, 32'd4);
        @(negedge clk);
        expect_out("p3_5", 16'd3, 16'd5, 1'b0);
        check("p3_5_s3_th", {16'd0, th3}, 32'd3);
        check("p3_5_s3_tl", {16'd0, tl3}, 32'd5);

        // Minimum widths.
        vc0 = vcount;
        repeat (10) begin
            phase(1'b0, 1);
            phase(1'b1, 1);
        end
        phase(1'b0, 6);
        expect_out("min", 16'd1, 16'd1, 1'b0);
        check("min_count", vcount - vc0, 32'd10);

        // Saturated high phase.
        phase(1'b1, 70000);
        phase(1'b0, 4);
        phase(1'b1, 6);
        expect_out("sat", 16'hFFFF, 16'd4, 1'b1);
        check("sat_s3_ovf", {31'd0, o3}, 32'd1);
        phase(1'b0, 5);
        phase(1'b1, 6);
        expect_out("after_sat", 16'd6, 16'd5, 1'b0);

        // Enable dropped mid-high.
        phase(1'b0, 7);
        phase(1'b1, 6);
        vc0 = vcount;
        en = 1'b0;
        phase(1'b1, 10);
        en = 1'b1;
        phase(1'b1, 3);
        phase(1'b0, 5);
        phase(1'b1, 3);
        phase(1'b0, 5);
        expect_out("en_hold", 16'd6, 16'd7, 1'b0);
        check("en_no_valid", vcount - vc0, 32'd0);
        phase(1'b1, 6);
        expect_out("en_clean", 16'd3, 16'd5, 1'b0);
        check("en_one_valid", vcount - vc0, 32'd1);

        // Reset mid-period.
        phase(1'b0, 5);
        phase(1'b1, 2);
        rst = 1'b0;
        phase(1'b1, 2);
        rst = 1'b1;
        expect_out("midrst", 16'd0, 16'd0, 1'b0);
        phase(1'b1, 3);
        phase(1'b0, 5);
        phase(1'b1, 3);
        phase(1'b0, 5);
        phase(1'b1, 6);
        expect_out("post_rst", 16'd3, 16'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
